oc8051_cxrom_arb: RTL
=====================

Name: oc8051_cxrom_arb

Overview:
Two-port arbiter and sequencer in front of the combinational 32-bit code ROM.
- It shares the ROM between the oc8051 instruction-fetch port (CPU) and a secure-boot burst reader (BST).
- BST streams consecutive ROM words to a measurement/hash engine.
- CPU has priority, and a starvation counter guarantees BST progress.
- Read responses are registered: 1-cycle latency from grant to data.

Parameters:
MAX_WAIT, 4, max consecutive cycles BST may be denied while it wants to issue; legal range 1..15
LEN_W, 12, width of burst length in words

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU fetch request, level, sampled every cycle
cpu_addr  in  16  CPU fetch byte address
cpu_ack  out  1  registered; data for the address granted last cycle is valid
cpu_data  out  32  registered ROM word for CPU
bst_start  in  1  start burst pulse; honoured only in IDLE
bst_base  in  16  burst start byte address, latched on start
bst_len  in  LEN_W  burst length in 32-bit words, latched on start
bst_busy  out  1  high in BURST or DRAIN
bst_done  out  1  one-cycle pulse at burst completion
bst_valid  out  1  burst output word valid
bst_data  out  32  burst output word
bst_ready  in  1  consumer accepts bst_data when bst_valid&&bst_ready
rom_addr  out  16  combinational address to ROM
rom_data  in  32  combinational ROM data

Behaviour:
- Reset: state IDLE.
  - cpu_ack=0, cpu_data=0, bst_valid=0, bst_data=0, bst_busy=0, bst_done=0.
  - ptr=0, remaining=0, wait_cnt=0.
  - Reset mid-burst aborts the burst; no bst_done is generated.
- bst_want = (state==BURST) && (remaining!=0) && (!bst_valid || bst_ready).
- Grant, combinational, evaluated each cycle:
  - grant_bst = bst_want && (!cpu_req || wait_cnt==MAX_WAIT).
  - grant_cpu = cpu_req && !grant_bst.
- rom_addr = grant_bst ? ptr : cpu_addr. cpu_addr is the default when idle.
- On a grant_cpu edge: cpu_data<=rom_data, cpu_ack<=1. Otherwise cpu_ack<=0 and cpu_data holds.
  - A held cpu_req gets one ack per granted cycle.
  - A denied cycle yields cpu_ack=0 the next cycle; the CPU must re-present the address.
- On a grant_bst edge: bst_data<=rom_data, bst_valid<=1, ptr<=ptr+4 (mod 2^16, wraps 0xFFFC->0x0000), remaining<=remaining-1.
- If there is no grant_bst and bst_valid&&bst_ready, then bst_valid<=0.
- While bst_valid&&!bst_ready, bst_data is stable.
- wait_cnt:
  - cleared on grant_bst or when !bst_want.
  - incremented (saturating at MAX_WAIT) when bst_want && grant_cpu.
- FSM:
  - IDLE: on bst_start, latch ptr<=bst_base and remaining<=bst_len.
    - If bst_len==0: bst_done pulses next cycle and state stays IDLE.
    - Else go to BURST.
  - BURST: issue reads as granted. The cycle that issues the last word (remaining==1 && grant_bst) goes to DRAIN.
  - DRAIN: when !bst_valid, or bst_valid&&bst_ready, go to IDLE and pulse bst_done. bst_done goes high the cycle after the final handshake.
  - bst_start is ignored in BURST and DRAIN.
- bst_busy=1 iff state is BURST or DRAIN (registered with state).

Test Plan:
- Reset with random inputs held 3 cycles -> all outputs 0 and rom_addr==cpu_addr; after release with no requests, outputs stay 0.
- CPU only: cpu_req=1, cpu_addr=0x0010 -> next cycle cpu_ack=1, cpu_data=ROM[0x0010..0x0013]; addr 0x0014 the following cycle -> ack with that word.
- Burst alone: bst_base=0x0100, bst_len=3, bst_ready=1 -> bst_valid on 3 consecutive cycles with words at 0x0100, 0x0104, 0x0108; bst_done one cycle after the last handshake; bst_busy drops with it.
- Contention: cpu_req held continuously, burst len=2, MAX_WAIT=4 -> BST granted on the 5th cycle of wanting; cpu_ack=0 exactly on the following cycle; second BST word granted after 4 more CPU grants.
- Backpressure and wrap: base 0xFFFC, len 2, bst_ready=0 for 5 cycles -> bst_valid held with stable word 0xFFFC and no further rom_addr=ptr cycles; after bst_ready=1, the next word is from 0x0000.
- Edge cases:
  - bst_len=0 -> single bst_done pulse; bst_busy never rises.
  - bst_start during BURST -> ignored.
  - rst asserted mid-BURST -> IDLE, bst_valid=0, no bst_done.

Source files
------------

// File: rtl/oc8051_cxrom_arb.sv
// Shares the combinational code ROM between the oc8051 fetch port and a secure-boot burst reader.
// CPU has priority; a starvation counter forces a burst grant after MAX_WAIT denied cycles.
module oc8051_cxrom_arb #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned LEN_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic [15:0]      cpu_addr,
    output logic             cpu_ack,
    output logic [31:0]      cpu_data,
    input  logic             bst_start,
    input  logic [15:0]      bst_base,
    input  logic [LEN_W-1:0] bst_len,
    output logic             bst_busy,
    output logic             bst_done,
    output logic             bst_valid,
    output logic [31:0]      bst_data,
    input  logic             bst_ready,
    output logic [15:0]      rom_addr,
    input  logic [31:0]      rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t             state_q, state_d;
    logic [15:0]        ptr_q, ptr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic [31:0]        cpu_data_q, cpu_data_d;
    logic               bst_valid_q, bst_valid_d;
    logic [31:0]        bst_data_q, bst_data_d;
    logic               bst_busy_q, bst_busy_d;
    logic               bst_done_q, bst_done_d;

    logic               bst_want;
    logic               grant_bst;
    logic               grant_cpu;

    // A burst read may only issue when the output slot is free or being emptied this cycle.
    always_comb begin
        bst_want  = (state_q == BURST) && (remaining_q != '0) && (!bst_valid_q || bst_ready);
        grant_bst = bst_want && (!cpu_req || (wait_cnt_q == WAIT_MAX));
        grant_cpu = cpu_req && !grant_bst;
        rom_addr  = grant_bst ? ptr_q : cpu_addr;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        cpu_ack_d   = 1'b0;
        cpu_data_d  = cpu_data_q;
        bst_valid_d = bst_valid_q;
        bst_data_d  = bst_data_q;
        bst_done_d  = 1'b0;

        if (grant_cpu) begin
            cpu_ack_d  = 1'b1;
            cpu_data_d = rom_data;
        end

        if (grant_bst) begin
            bst_valid_d = 1'b1;
            bst_data_d  = rom_data;
            ptr_d       = ptr_q + 16'd4;
            remaining_d = remaining_q - LEN_W'(1);
        end else if (bst_valid_q && bst_ready) begin
            bst_valid_d = 1'b0;
        end

        if (grant_bst || !bst_want) begin
            wait_cnt_d = '0;
        end else if (grant_cpu && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (bst_start) begin
                    ptr_d       = bst_base;
                    remaining_d = bst_len;
                    if (bst_len == '0) begin
                        bst_done_d = 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (grant_bst && (remaining_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Completion is reported only once the last word has left the output slot.
                if (!bst_valid_q || bst_ready) begin
                    state_d    = IDLE;
                    bst_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bst_busy_d = (state_d == BURST) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_data_q  <= '0;
            bst_valid_q <= 1'b0;
            bst_data_q  <= '0;
            bst_busy_q  <= 1'b0;
            bst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_data_q  <= cpu_data_d;
            bst_valid_q <= bst_valid_d;
            bst_data_q  <= bst_data_d;
            bst_busy_q  <= bst_busy_d;
            bst_done_q  <= bst_done_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_data  = cpu_data_q;
    assign bst_valid = bst_valid_q;
    assign bst_data  = bst_data_q;
    assign bst_busy  = bst_busy_q;
    assign bst_done  = bst_done_q;

endmodule
